fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the ARM pipeline. It replaces the single-cycle PC register and instruction-memory pair with a prefetch engine. The engine talks to a variable-latency instruction memory over a req/ack handshake and buffers fetched words in a DEPTH-entry FIFO. It presents one instruction at a time to the ID stage, with freeze and branch-flush semantics matching the rest of the pipeline.

---
 rtl/fetch_prefetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch front end with prefetch. A small FSM issues one request
// at a time to a variable-latency instruction memory (req/ack handshake).
// Returned words are buffered in a DEPTH-entry FIFO. The FIFO head is
// presented to the ID stage. freeze holds the head. branch_taken flushes the
// FIFO and redirects the fetch address.
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds 32-bit fetch_count and
// drop_count outputs.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   freeze            hold the presented instruction (no pop)
//   branch_taken      flush FIFO and redirect to branch_addr
//   branch_addr       redirect target (word aligned)
//   imem_req          registered request, high while a fetch is outstanding
//   imem_addr         registered request address
//   imem_ack          one-cycle response strobe, qualifies imem_rdata
//   imem_rdata        fetched word
//   valid             instruction/pc are meaningful
//   instruction       FIFO head word (0 when !valid)
//   pc                FIFO head address + 4 (0 when !valid)
//   fetch_count       pushes into the FIFO            (FETCH_PERF_CNT_EN)
//   drop_count        discarded responses + flushed entries (FETCH_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_addr,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_fpc, w_fpc_nxt;
    logic [ADDR_WIDTH-1:0]  r_tgt, w_tgt_nxt;
    logic [CW-1:0]          r_count, w_count_nxt;
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_mem_pc    [DEPTH];

    logic                   w_push, w_pop, w_discard, w_space;
    logic [ADDR_WIDTH-1:0]  w_fpc_inc;

    assign w_fpc_inc = r_fpc + ADDR_WIDTH'(4);
    assign valid     = (r_count != '0);
    assign w_pop     = valid && !freeze && !branch_taken;
    // A response is kept only in REQ and only when no redirect arrives with it.
    assign w_push    = (r_state == REQ) && imem_ack && !branch_taken;
    assign w_discard = imem_ack && (((r_state == REQ) && branch_taken) || (r_state == DROP));

    // Occupancy after this cycle's push/pop; a flush empties the FIFO.
    assign w_count_nxt = branch_taken ? '0
                       : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_space     = (w_count_nxt < DEPTH_C);

    assign imem_req    = (r_state != IDLE);
    assign imem_addr   = r_fpc;
    assign instruction = valid ? r_mem_instr[r_rptr] : '0;
    assign pc          = valid ? r_mem_pc[r_rptr]    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_fpc   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
        end
    end

    // Redirect target is only read in DROP, after it has been written.
    always_ff @(posedge clk) begin
        r_tgt <= w_tgt_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            IDLE: begin
                if (branch_taken) begin
                    w_fpc_nxt   = branch_addr;
                    w_state_nxt = REQ;
                end else if (w_space) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        w_fpc_nxt   = branch_addr;
                        w_state_nxt = REQ;
                    end else begin
                        w_fpc_nxt   = w_fpc_inc;
                        w_state_nxt = w_space ? REQ : IDLE;
                    end
                end else if (branch_taken) begin
                    // Request must stay stable until its ack; remember target.
                    w_tgt_nxt   = branch_addr;
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    // A redirect arriving with the ack is the newest target.
                    w_fpc_nxt   = branch_taken ? branch_addr : r_tgt;
                    w_state_nxt = REQ;
                end else if (branch_taken) begin
                    w_tgt_nxt = branch_addr;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (branch_taken) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= w_fpc_inc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            // Flushed entries: the whole FIFO, since a branch blocks the pop.
            r_drop_cnt <= r_drop_cnt + 32'(w_discard)
                        + (branch_taken ? 32'(r_count) : 32'd0);
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign drop_count  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Directed testbench for fetch_prefetch_unit. The memory response is driven
// from the stimulus process: zero-wait responses echo the request address
// as data; longer latencies and stray acks are driven explicitly.
// Compile with FETCH_PERF_CNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    int n_chk;
    int n_pass;

    fetch_prefetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .instruction  (instruction),
        .pc           (pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: answer the current request with its own address.
    task automatic zw();
        imem_ack   = imem_req;
        imem_rdata = imem_addr;
    endtask

    // Leaves the bench in cycle 0: reset just released, FSM still IDLE.
    task automatic do_reset();
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;

        // Reset state
        tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr,         32'd0);
        chk("rst_valid", {31'd0, valid},    32'd0);
        chk("rst_instr", instruction,       32'd0);
        chk("rst_pc",    pc,                32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fcnt",  fetch_count,       32'd0);
        chk("rst_dcnt",  drop_count,        32'd0);
`endif

        // Zero-wait streaming after reset release
        do_reset();
        chk("t1_req_c0", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_req",  {31'd0, imem_req}, 32'd1);
            chk("t1_addr", imem_addr, 32'(4 * (i - 1)));
            if (i == 1) begin
                chk("t1_valid_c1", {31'd0, valid}, 32'd0);
            end else begin
                chk("t1_valid", {31'd0, valid}, 32'd1);
                chk("t1_pc",    pc,             32'(4 * (i - 1)));
                chk("t1_instr", instruction,    32'(4 * (i - 2)));
            end
            zw();
        end

        // Freeze fills the FIFO, request drops, then drains on release
        do_reset();
        freeze = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            zw();
        end
        chk("t2_req_full",  {31'd0, imem_req}, 32'd0);
        chk("t2_valid",     {31'd0, valid},    32'd1);
        chk("t2_instr",     instruction,       32'd0);
        chk("t2_pc",        pc,                32'd4);
        chk("t2_addr",      imem_addr,         32'd16);
        // Stray ack with no request outstanding must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000DEAD;
        tick();
        chk("t2_req_held",  {31'd0, imem_req}, 32'd0);
        chk("t2_instr_held", instruction,      32'd0);
        freeze   = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("t2_req_back",  {31'd0, imem_req}, 32'd1);
        chk("t2_addr_back", imem_addr,         32'd16);
        chk("t2_pop1",      instruction,       32'd4);
        chk("t2_pop1_pc",   pc,                32'd8);
        zw();
        tick();
        chk("t2_pop2",      instruction,       32'd8);
        zw();
        tick();
        chk("t2_pop3",      instruction,       32'd12);
        zw();
        tick();
        chk("t2_pop4",      instruction,       32'd16);
        chk("t2_pop4_pc",   pc,                32'd20);

        // 3-cycle latency, branch while waiting: response dropped
        do_reset();
        tick();
        chk("t3_req_c1",  {31'd0, imem_req}, 32'd1);
        chk("t3_addr_c1", imem_addr,         32'd0);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("t3_req_wait",  {31'd0, imem_req}, 32'd1);
        chk("t3_addr_hold", imem_addr,         32'd0);
        chk("t3_valid_c2",  {31'd0, valid},    32'd0);
        tick();
        chk("t3_addr_hold2", imem_addr, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00000BAD;
        tick();
        imem_ack = 1'b0;
        chk("t3_addr_redir", imem_addr,         32'h100);
        chk("t3_req_redir",  {31'd0, imem_req}, 32'd1);
        chk("t3_valid_c4",   {31'd0, valid},    32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t3_dcnt",       drop_count,        32'd1);
        chk("t3_fcnt",       fetch_count,       32'd0);
`endif
        tick();
        tick();
        chk("t3_valid_c6", {31'd0, valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00000011;
        tick();
        imem_ack = 1'b0;
        chk("t3_valid_c7", {31'd0, valid}, 32'd1);
        chk("t3_pc",       pc,             32'h104);
        chk("t3_instr",    instruction,    32'h11);
        chk("t3_addr_c7",  imem_addr,      32'h104);

        // Branch coincident with ack, zero-wait memory
        do_reset();
        tick();
        zw();
        tick();
        zw();
        tick();
        chk("t4_addr_c3",  imem_addr,      32'd8);
        chk("t4_valid_c3", {31'd0, valid}, 32'd1);
        zw();
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("t4_addr_br",  imem_addr,      32'h200);
        chk("t4_valid_br", {31'd0, valid}, 32'd0);
        chk("t4_pc_br",    pc,             32'd0);
        chk("t4_instr_br", instruction,    32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_dcnt",     drop_count,     32'd2);
        chk("t4_fcnt",     fetch_count,    32'd2);
`endif
        zw();
        tick();
        chk("t4_valid_c5", {31'd0, valid}, 32'd1);
        chk("t4_pc_c5",    pc,             32'h204);
        chk("t4_instr_c5", instruction,    32'h200);

        // Address wrap at the top of the address space
        do_reset();
        tick();
        zw();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        zw();
        tick();
        chk("t5_valid", {31'd0, valid}, 32'd1);
        chk("t5_pc",    pc,             32'h0);
        chk("t5_instr", instruction,    32'hFFFF_FFFC);
        chk("t5_addr",  imem_addr,      32'h0);

        // Reset asserted mid-request, late ack ignored
        do_reset();
        tick();
        zw();
        tick();
        zw();
        tick();
        chk("t6_addr_pre",  imem_addr,      32'd8);
        chk("t6_valid_pre", {31'd0, valid}, 32'd1);
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req",   {31'd0, imem_req}, 32'd0);
        chk("t6_addr",  imem_addr,         32'd0);
        chk("t6_valid", {31'd0, valid},    32'd0);
        chk("t6_instr", instruction,       32'd0);
        chk("t6_pc",    pc,                32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fcnt",  fetch_count,       32'd0);
`endif
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000EEEE;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_valid_after", {31'd0, valid},    32'd0);
        chk("t6_req_after",   {31'd0, imem_req}, 32'd1);
        chk("t6_addr_after",  imem_addr,         32'd0);
        imem_ack = 1'b0;
        tick();
        chk("t6_valid_late", {31'd0, valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
